instr_line_loader: RTL and testbench
====================================

INSTR_LINE_LOADER -- requirements
Module: instr_line_loader

Interface
REQ-001 Parameter PCW, default 32, address width.
REQ-002 Parameter INW, default 512, instruction-cache line width.
REQ-003 Parameter BEATW, default 64, host read beat width; INW SHALL be an integer multiple of BEATW; NB = INW/BEATW (8 at defaults).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a program load when idle.
REQ-007 base_addr  input  PCW  byte address of the first program line in host memory.
REQ-008 num_lines  input  16  number of INW-bit lines to load.
REQ-009 rd_req_valid  output  1  host read request valid.
REQ-010 rd_req_addr  output  PCW  byte address of the requested beat.
REQ-011 rd_req_ready  input  1  host accepts request when high with rd_req_valid.
REQ-012 rd_rsp_valid  input  1  read-response beat valid.
REQ-013 rd_rsp_data  input  BEATW  read-response beat data.
REQ-014 instr_write_en  output  1  one-cycle cache line write strobe.
REQ-015 instr_data_out  output  INW  assembled line; valid while instr_write_en is high.
REQ-016 line_idx  output  16  index of the line being loaded or written.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on load completion.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, WRITE, DONE.
REQ-020 IDLE: on start=1, latch base_addr and num_lines, clear line_idx and beat counter; go to REQ if num_lines!=0, else DONE.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 REQ: rd_req_valid=1, rd_req_addr = latched base + (line_idx*NB + beat)*(BEATW/8), computed modulo 2^PCW (wraps silently); advance to WAIT on the cycle rd_req_ready=1, else hold the request and address stable.
REQ-023 Exactly one request SHALL be outstanding at any time; rd_req_valid=0 outside REQ.
REQ-024 WAIT: on rd_rsp_valid=1, write rd_rsp_data into line-buffer bits [beat*BEATW +: BEATW]; if beat==NB-1 go to WRITE and clear beat, else increment beat and return to REQ.
REQ-025 rd_rsp_valid SHALL be ignored in every state other than WAIT.
REQ-026 WRITE: instr_write_en=1 for exactly one cycle with the complete line on instr_data_out and line_idx equal to that line's index; then increment line_idx; go to DONE if the incremented value equals latched num_lines, else REQ.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; line_idx holds the final count.
REQ-028 instr_data_out SHALL hold the last written line until the next WRITE (registered output, no glitching).
REQ-029 Changes of base_addr or num_lines after start SHALL NOT affect an in-progress load.
REQ-030 Minimum latency per line with ready and response returning the cycle after acceptance SHALL be 2*NB+1 cycles; the load ends with done one cycle after the last WRITE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and clear line_idx, beat counter, line buffer, instr_data_out, rd_req_valid, instr_write_en, busy and done to 0, regardless of clock.
REQ-032 Reset asserted mid-load SHALL abandon the load with no further write strobes; responses arriving after reset SHALL be ignored.

Verification
REQ-033 start, base=0x1000, num_lines=1, ready always 1, beats 0x0..0x7 -> 8 requests at 0x1000,0x1008..0x1038; one write strobe, data bits[63:0]=0, bits[511:448]=7; done one cycle after.
REQ-034 start, num_lines=0 -> no rd_req_valid; busy high one cycle; done pulse on the following cycle.
REQ-035 num_lines=2, rd_req_ready low 3 cycles on each beat -> address stable while stalled; 2 strobes with line_idx 0 then 1; second line's first address = base+0x40.
REQ-036 base=0xFFFFFFC0, num_lines=2 -> second line's first request address wraps to 0x00000000.
REQ-037 rst pulsed while in WAIT for beat 3 of line 0 -> all outputs 0 immediately; later rd_rsp_valid pulses produce no write strobe; a new start loads correctly.
REQ-038 start pulsed while busy and spurious rd_rsp_valid in REQ -> no effect on addresses, data or line count.

Source files
------------

// File: rtl/instr_line_loader.sv
// Program loader: fetches num_lines cache lines from host memory one beat at a time
// and emits each assembled line with a one-cycle write strobe.
`timescale 1ns/1ps
module instr_line_loader #(
  parameter int unsigned PCW   = 32,
  parameter int unsigned INW   = 512,
  parameter int unsigned BEATW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PCW-1:0]   base_addr,
  input  logic [15:0]      num_lines,
  output logic             rd_req_valid,
  output logic [PCW-1:0]   rd_req_addr,
  input  logic             rd_req_ready,
  input  logic             rd_rsp_valid,
  input  logic [BEATW-1:0] rd_rsp_data,
  output logic             instr_write_en,
  output logic [INW-1:0]   instr_data_out,
  output logic [15:0]      line_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NB    = INW / BEATW;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned BYTES = BEATW / 8;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_e;

  state_e           state_q, state_d;
  logic [PCW-1:0]   base_q, base_d;
  logic [15:0]      num_q, num_d;
  logic [15:0]      line_q, line_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [INW-1:0]   buf_q, buf_d;
  logic [INW-1:0]   data_q, data_d;
  logic [PCW-1:0]   beat_num;
  logic [15:0]      line_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    line_d    = line_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    data_d    = data_q;
    line_next = line_q + 16'd1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_lines;
          line_d  = '0;
          beat_d  = '0;
          state_d = (num_lines != 16'd0) ? REQ : DONE;
        end
      end
      REQ: begin
        if (rd_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (rd_rsp_valid) begin
          buf_d[int'(beat_q) * BEATW +: BEATW] = rd_rsp_data;
          if (beat_q == BW'(NB - 1)) begin
            // Output register is loaded here so the full line is stable throughout WRITE.
            data_d  = buf_d;
            beat_d  = '0;
            state_d = WRITE;
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = REQ;
          end
        end
      end
      WRITE: begin
        line_d  = line_next;
        state_d = (line_next == num_q) ? DONE : REQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_num       = PCW'(line_q) * PCW'(NB) + PCW'(beat_q);
    rd_req_addr    = base_q + beat_num * PCW'(BYTES);
    rd_req_valid   = (state_q == REQ);
    instr_write_en = (state_q == WRITE);
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    line_idx       = line_q;
    instr_data_out = data_q;
  end

endmodule

// File: tb/tb_instr_line_loader.sv
// Bench for instr_line_loader: host memory responder, queue-based expectation model
// and a per-cycle checker, driven by directed load scenarios.
`timescale 1ns/1ps
module tb_instr_line_loader;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_lines;
  logic         rd_req_valid;
  logic [31:0]  rd_req_addr;
  logic         rd_req_ready;
  logic         rd_rsp_valid;
  logic [63:0]  rd_rsp_data;
  logic         instr_write_en;
  logic [511:0] instr_data_out;
  logic [15:0]  line_idx;
  logic         busy;
  logic         done;

  instr_line_loader #(.PCW(32), .INW(512), .BEATW(64)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .instr_write_en(instr_write_en), .instr_data_out(instr_data_out),
    .line_idx(line_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expectation model
  logic [31:0]  exp_addr[$];
  logic [511:0] exp_line[$];
  int           exp_idx[$];
  int           exp_done = 0;
  int           exp_n = 0;
  logic [511:0] hold_exp = '0;

  // host / logs
  logic [31:0]  salt = '0;
  logic [31:0]  ref_addr = '0;
  int           stall_n = 0;
  bit           spur_en = 0;
  int           block_at = 1000000;
  int           inject = 0;
  int           acc_cnt = 0;
  bit           acc_pending = 0;
  logic [31:0]  acc_addr = '0;
  logic [31:0]  acc_log[$];
  int           wr_idx_log[$];
  int           wr_count = 0;
  logic [511:0] last_wr = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] host_word(input logic [31:0] a);
    logic [31:0] off;
    off = (a - ref_addr) >> 3;
    return {salt, off};
  endfunction

  task automatic model_load(input logic [31:0] base, input int n);
    logic [511:0] line;
    logic [31:0]  a;
    for (int l = 0; l < n; l++) begin
      line = '0;
      for (int b = 0; b < NB; b++) begin
        a = base + 32'((l * NB + b) * 8);
        exp_addr.push_back(a);
        line[b*64 +: 64] = host_word(a);
      end
      exp_line.push_back(line);
      exp_idx.push_back(l);
    end
    exp_done = 1;
    exp_n = n;
  endtask

  // host memory responder: one response the cycle after each accepted request
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_rsp_valid = 1'b0;
      if (rst) begin
        acc_pending = 0;
        rd_req_ready = 1'b0;
        stall_cnt = 0;
      end else begin
        if (inject > 0) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data = {$urandom, $urandom};
          inject--;
        end else if (acc_pending && acc_cnt <= block_at) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data = host_word(acc_addr);
          acc_pending = 0;
        end else if (spur_en && rd_req_valid) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data = {$urandom, $urandom};
        end
        if (rd_req_valid && !acc_pending) begin
          if (stall_cnt < stall_n) begin
            rd_req_ready = 1'b0;
            stall_cnt++;
          end else begin
            rd_req_ready = 1'b1;
            stall_cnt = 0;
            acc_pending = 1;
            acc_addr = rd_req_addr;
            acc_cnt++;
            acc_log.push_back(rd_req_addr);
          end
        end else begin
          rd_req_ready = 1'b0;
        end
      end
    end
  end

  // per-cycle checker against the model
  initial begin
    bit prev_wr;
    prev_wr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_req_valid) begin
          if (exp_addr.size() == 0) check("req_unexpected", 512'(rd_req_valid), 512'd0);
          else begin
            check("req_addr", 512'(rd_req_addr), 512'(exp_addr[0]));
            if (rd_req_ready) void'(exp_addr.pop_front());
          end
        end
        if (instr_write_en) begin
          wr_count++;
          wr_idx_log.push_back(int'(line_idx));
          last_wr = instr_data_out;
          if (exp_line.size() == 0) check("wr_unexpected", 512'(instr_write_en), 512'd0);
          else begin
            check("wr_line_idx", 512'(line_idx), 512'(exp_idx[0]));
            check("wr_data", instr_data_out, exp_line[0]);
            hold_exp = exp_line[0];
            void'(exp_line.pop_front());
            void'(exp_idx.pop_front());
          end
        end else begin
          check("data_hold", instr_data_out, hold_exp);
        end
        if (done) begin
          check("done_expected", 512'(exp_done), 512'd1);
          check("done_lines_left", 512'(exp_line.size()), 512'd0);
          check("done_line_idx", 512'(line_idx), 512'(exp_n));
          if (exp_n != 0) check("done_after_write", 512'(prev_wr), 512'd1);
          exp_done = 0;
        end
        prev_wr = instr_write_en;
      end else begin
        prev_wr = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, 512'(rd_req_valid), 512'd0);
    check({tag, "_req_addr"}, 512'(rd_req_addr), 512'd0);
    check({tag, "_write_en"}, 512'(instr_write_en), 512'd0);
    check({tag, "_data_out"}, instr_data_out, 512'd0);
    check({tag, "_line_idx"}, 512'(line_idx), 512'd0);
    check({tag, "_busy"}, 512'(busy), 512'd0);
    check({tag, "_done"}, 512'(done), 512'd0);
  endtask

  task automatic run_load(input logic [31:0] base, input int n, input logic [31:0] salt_v,
                          input int stall, input bit spur, input bit disturb, input int exp_cyc);
    int cyc;
    salt = salt_v;
    ref_addr = base;
    stall_n = stall;
    spur_en = spur;
    acc_cnt = 0;
    acc_log.delete();
    wr_idx_log.delete();
    model_load(base, n);
    base_addr = base;
    num_lines = 16'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      if (disturb && cyc == 5) begin
        start = 1'b1;
        base_addr = 32'h0000_9000;
        num_lines = 16'd7;
      end else if (disturb && cyc == 6) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 512'(done), 512'd1);
    if (exp_cyc >= 0) check("load_cycles", 512'(cyc), 512'(exp_cyc));
    check("busy_at_done", 512'(busy), 512'd1);
    check("addr_left", 512'(exp_addr.size()), 512'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 512'(done), 512'd0);
    check("idle_after_done", 512'(busy), 512'd0);
    check("done_count", 512'(exp_done), 512'd0);
    spur_en = 0;
  endtask

  initial begin
    int wrc;
    int k;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_lines = '0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single line, beat data 0..7
    run_load(32'h0000_1000, 1, 32'h0, 0, 0, 0, 18);
    check("l1_req_count", 512'(acc_log.size()), 512'd8);
    check("l1_first_addr", 512'(acc_log[0]), 512'h1000);
    check("l1_last_addr", 512'(acc_log[7]), 512'h1038);
    check("l1_low_beat", 512'(last_wr[63:0]), 512'd0);
    check("l1_beat1", 512'(last_wr[127:64]), 512'd1);
    check("l1_high_beat", 512'(last_wr[511:448]), 512'd7);

    // zero lines
    wrc = wr_count;
    run_load(32'h0000_2000, 0, 32'h0, 0, 0, 0, 1);
    check("z_req_count", 512'(acc_log.size()), 512'd0);
    check("z_no_write", 512'(wr_count), 512'(wrc));

    // two lines with 3-cycle ready stalls per beat
    run_load(32'h0000_4000, 2, 32'h0000_0011, 3, 0, 0, 83);
    check("st_req_count", 512'(acc_log.size()), 512'd16);
    check("st_line1_addr", 512'(acc_log[8]), 512'h4040);
    check("st_wr_count", 512'(wr_idx_log.size()), 512'd2);
    check("st_wr_idx0", 512'(wr_idx_log[0]), 512'd0);
    check("st_wr_idx1", 512'(wr_idx_log[1]), 512'd1);

    // address wrap
    run_load(32'hFFFF_FFC0, 2, 32'hCAFE_0000, 0, 0, 0, 35);
    check("wr_line0_last", 512'(acc_log[7]), 512'hFFFF_FFF8);
    check("wr_line1_first", 512'(acc_log[8]), 512'h0);

    // reset while waiting on beat 3 of line 0
    salt = 32'h0000_0033;
    ref_addr = 32'h0000_3000;
    stall_n = 0;
    block_at = 3;
    acc_cnt = 0;
    acc_log.delete();
    model_load(32'h0000_3000, 1);
    base_addr = 32'h0000_3000;
    num_lines = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (acc_cnt < 4 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_reached_beat3", 512'(acc_cnt), 512'd4);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_addr.delete();
    exp_line.delete();
    exp_idx.delete();
    exp_done = 0;
    hold_exp = '0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    block_at = 1000000;
    wrc = wr_count;
    inject = 4;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_strobe", 512'(wr_count), 512'(wrc));
    check("rst_idle", 512'(busy), 512'd0);
    run_load(32'h0000_3000, 1, 32'h0000_0044, 0, 0, 0, 18);
    check("post_rst_first_addr", 512'(acc_log[0]), 512'h3000);

    // start while busy, input changes mid-load, spurious responses in REQ
    wrc = wr_count;
    run_load(32'h0000_5000, 3, 32'h0000_0055, 1, 1, 1, 76);
    check("dist_req_count", 512'(acc_log.size()), 512'd24);
    check("dist_last_addr", 512'(acc_log[23]), 512'h50B8);
    check("dist_wr_count", 512'(wr_count - wrc), 512'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
